// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Instruction-memory request channel between the fetch sequencer and the
//   instruction memory.
//
//   Handshake: imemReq is held high with imemAddr stable until the cycle in
//   which imemAck is seen high. That cycle completes the request. imemAck
//   sampled while imemReq is low has no effect.
//
//   Signals:
//     imemReq   request from the sequencer
//     imemAddr  request address (32 bits)
//     imemAck   memory accepted/returned the request this cycle
//   Modports:
//     master  sequencer side (drives req/addr, samples ack)
//     slave   memory side (samples req/addr, drives ack)
// ---------------------------------------------------------------------------
interface pc_sequencer_if;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;

   modport master (output imemReq, output imemAddr, input imemAck);
   modport slave  (input imemReq, input imemAddr, output imemAck);
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Fetch controller in front of the program_counter register. Each cycle it
//   picks the PC's next value (hold, +4, branch target, trap vector or reset
//   vector), runs the instruction-memory req/ack handshake and squashes
//   fetches that complete while a redirect is active.
//
//   Build option: define PC_ALIGN_CHECK_EN to turn taken branches with a
//   misaligned target into traps and to report them on misalign. Without it,
//   the low two target bits are dropped and misalign is constant 0.
//
//   Parameters:
//     RESET_VECTOR    PC value loaded after reset release
//     TRAP_VECTOR     redirect address for traps
//   Ports:
//     clk             system clock, rising edge
//     rst             asynchronous active-low reset
//     currentAddress  present program_counter value
//     nextAddress     value the program_counter loads on the next edge
//     imem            instruction-memory channel (master side)
//     stall           downstream cannot accept a new fetch
//     branchTaken     taken-branch pulse, branchTarget valid with it
//     branchTarget    branch target address
//     trap            trap pulse
//     fetchValid      registered pulse: fetch at fetchAddress completed on path
//     fetchAddress    address of the completed fetch
//     misalign        registered pulse: misaligned branch converted to a trap
//     dbg_state       current FSM state (0 BOOT, 1 REQ, 2 STALL)
// ---------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           currentAddress,
   output logic [31:0]           nextAddress,
   pc_sequencer_if.master        imem,
   input  logic                  stall,
   input  logic                  branchTaken,
   input  logic [31:0]           branchTarget,
   input  logic                  trap,
   output logic                  fetchValid,
   output logic [31:0]           fetchAddress,
   output logic                  misalign,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      REQ   = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t      state, state_next;

   // Redirect that arrived while a request was still waiting for its ack.
   // pend_trap marks that the held target is the trap vector, which a later
   // branch must not overwrite.
   logic        pend_valid, pend_valid_next;
   logic        pend_trap, pend_trap_next;
   logic [31:0] pend_target, pend_target_next;

   logic        bad_branch;
   logic [31:0] br_target;
   logic        trap_eff, branch_eff, redirect;
   logic [31:0] rt;
   logic        req;
   logic        fetch_done;

`ifdef PC_ALIGN_CHECK_EN
   assign bad_branch = branchTaken && (branchTarget[1:0] != 2'b00);
   assign br_target  = branchTarget;
`else
   assign bad_branch = 1'b0;
   assign br_target  = branchTarget & 32'hFFFF_FFFC;
`endif

   // A misaligned branch behaves exactly like a trap, including priority.
   assign trap_eff   = trap | bad_branch;
   assign branch_eff = branchTaken & ~bad_branch;
   assign redirect   = trap_eff | branch_eff | pend_valid;

   always_comb begin
      rt = pend_target;
      if (trap_eff) begin
         rt = TRAP_VECTOR;
      end else if (branch_eff) begin
         rt = br_target;
      end
   end

   always_comb begin
      state_next       = state;
      nextAddress      = currentAddress;
      req              = 1'b0;
      fetch_done       = 1'b0;
      pend_valid_next  = pend_valid;
      pend_trap_next   = pend_trap;
      pend_target_next = pend_target;
      case (state)
         BOOT: begin
            nextAddress = RESET_VECTOR;
            state_next  = REQ;
         end
         REQ: begin
            req = 1'b1;
            if (imem.imemAck) begin
               if (redirect) begin
                  // Fetch completed on the wrong path: drop it and redirect.
                  nextAddress      = rt;
                  pend_valid_next  = 1'b0;
                  pend_trap_next   = 1'b0;
                  pend_target_next = '0;
               end else begin
                  nextAddress = currentAddress + 32'd4;
                  fetch_done  = 1'b1;
               end
               state_next = stall ? STALL : REQ;
            end else begin
               // PC must hold while the request is outstanding, so redirects
               // are parked until the ack arrives.
               if (trap_eff) begin
                  pend_valid_next  = 1'b1;
                  pend_trap_next   = 1'b1;
                  pend_target_next = TRAP_VECTOR;
               end else if (branch_eff && !pend_trap) begin
                  pend_valid_next  = 1'b1;
                  pend_target_next = br_target;
               end
            end
         end
         STALL: begin
            if (redirect) begin
               nextAddress      = rt;
               pend_valid_next  = 1'b0;
               pend_trap_next   = 1'b0;
               pend_target_next = '0;
            end
            if (!stall) begin
               state_next = REQ;
            end
         end
         default: begin
            nextAddress = RESET_VECTOR;
            state_next  = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= BOOT;
         pend_valid   <= 1'b0;
         pend_trap    <= 1'b0;
         pend_target  <= '0;
         fetchValid   <= 1'b0;
         fetchAddress <= '0;
      end else begin
         state        <= state_next;
         pend_valid   <= pend_valid_next;
         pend_trap    <= pend_trap_next;
         pend_target  <= pend_target_next;
         fetchValid   <= fetch_done;
         if (fetch_done) begin
            fetchAddress <= currentAddress;
         end
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misalign <= 1'b0;
      end else begin
         misalign <= bad_branch && (state != BOOT);
      end
   end
`else
   assign misalign = 1'b0;
`endif

   assign imem.imemReq  = req;
   assign imem.imemAddr = currentAddress;
   assign dbg_state     = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer. The bench owns the program_counter
//   register, drives inputs on the falling edge and samples 1 time unit later.
//   Completed fetches expected by the stimulus are queued and matched against
//   fetchValid/fetchAddress by a monitor.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc;
   logic [31:0] next_address;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        trap;
   logic        fetch_valid;
   logic [31:0] fetch_address;
   logic        misalign;
   logic [1:0]  dbg_state;

   pc_sequencer_if imem_if();

   pc_sequencer dut (
      .clk            (clk),
      .rst            (rst_n),
      .currentAddress (pc),
      .nextAddress    (next_address),
      .imem           (imem_if),
      .stall          (stall),
      .branchTaken    (branch_taken),
      .branchTarget   (branch_target),
      .trap           (trap),
      .fetchValid     (fetch_valid),
      .fetchAddress   (fetch_address),
      .misalign       (misalign),
      .dbg_state      (dbg_state)
   );

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [31:0] MIS_PC  = 32'h0000_0080;
   localparam logic        MIS_EXP = 1'b1;
`else
   localparam logic [31:0] MIS_PC  = 32'h0000_0100;
   localparam logic        MIS_EXP = 1'b0;
`endif

   // ---------------- clock / reset / PC register ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= 32'h0;
      else        pc <= next_address;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic        mon_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Completed fetches must arrive in order; with nothing expected, no
   // fetchValid pulse is allowed.
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            check("no_fetch", {31'b0, fetch_valid}, 32'h0);
         end else if (fetch_valid) begin
            check("fetch_addr", fetch_address, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver ----------------
   task automatic cyc(input logic a, input logic s, input logic b, input logic [31:0] bt,
                      input logic t, input logic er, input logic [31:0] ea,
                      input logic [31:0] en, input logic push);
      @(negedge clk);
      imem_if.imemAck = a;
      stall           = s;
      branch_taken    = b;
      branch_target   = bt;
      trap            = t;
      #1;
      check("imem_req", {31'b0, imem_if.imemReq}, {31'b0, er});
      check("imem_addr", imem_if.imemAddr, ea);
      check("next_address", next_address, en);
      if (push) exp_q.push_back(ea);
   endtask

   logic [31:0] pc_exp;
   logic        a;

   initial begin
      rst_n           = 1'b0;
      imem_if.imemAck = 1'b0;
      stall           = 1'b0;
      branch_taken    = 1'b0;
      branch_target   = 32'h0;
      trap            = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_req", {31'b0, imem_if.imemReq}, 32'h0);
      check("rst_next", next_address, 32'h0);
      check("rst_fvalid", {31'b0, fetch_valid}, 32'h0);
      check("rst_faddr", fetch_address, 32'h0);
      check("rst_misalign", {31'b0, misalign}, 32'h0);
      check("rst_state", {30'b0, dbg_state}, 32'h0);

      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      #1;
      check("boot_req", {31'b0, imem_if.imemReq}, 32'h0);
      check("boot_next", next_address, 32'h0);

      // Sequential fetch with ack every cycle, then ack withheld at 0x8.
      cyc(1, 0, 0, 0, 0, 1, 32'h0, 32'h4, 1);
      cyc(1, 0, 0, 0, 0, 1, 32'h4, 32'h8, 1);
      cyc(0, 0, 0, 0, 0, 1, 32'h8, 32'h8, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'h8, 32'h8, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'h8, 32'h8, 0);
      // Branch to 0x100 while waiting; ack two cycles later squashes 0x8.
      cyc(0, 0, 1, 32'h100, 0, 1, 32'h8, 32'h8, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'h8, 32'h8, 0);
      cyc(1, 0, 0, 0, 0, 1, 32'h8, 32'h100, 0);
      cyc(1, 0, 0, 0, 0, 1, 32'h100, 32'h104, 1);
      // Trap and branch together: trap wins.
      cyc(1, 0, 1, 32'h200, 1, 1, 32'h104, 32'h80, 0);
      cyc(1, 0, 0, 0, 0, 1, 32'h80, 32'h84, 1);
      // Pending branch overwritten by trap; later branch ignored.
      cyc(0, 0, 1, 32'h300, 0, 1, 32'h84, 32'h84, 0);
      cyc(0, 0, 0, 0, 1, 1, 32'h84, 32'h84, 0);
      cyc(0, 0, 1, 32'h400, 0, 1, 32'h84, 32'h84, 0);
      cyc(1, 0, 0, 0, 0, 1, 32'h84, 32'h80, 0);
      // Go to 0x10, ack with stall, hold stall 4 cycles (one with stray ack).
      cyc(1, 0, 1, 32'h10, 0, 1, 32'h80, 32'h10, 0);
      cyc(1, 1, 0, 0, 0, 1, 32'h10, 32'h14, 1);
      cyc(0, 1, 0, 0, 0, 0, 32'h14, 32'h14, 0);
      cyc(1, 1, 0, 0, 0, 0, 32'h14, 32'h14, 0);
      cyc(0, 1, 0, 0, 0, 0, 32'h14, 32'h14, 0);
      cyc(0, 1, 0, 0, 0, 0, 32'h14, 32'h14, 0);
      cyc(0, 0, 0, 0, 0, 0, 32'h14, 32'h14, 0);
      cyc(1, 0, 0, 0, 0, 1, 32'h14, 32'h18, 1);
      // Redirect taken directly while stalled.
      cyc(1, 1, 0, 0, 0, 1, 32'h18, 32'h1C, 1);
      cyc(0, 1, 1, 32'h40, 0, 0, 32'h1C, 32'h40, 0);
      cyc(0, 0, 0, 0, 0, 0, 32'h40, 32'h40, 0);
      cyc(1, 0, 0, 0, 0, 1, 32'h40, 32'h44, 1);
      // +4 wraps at the top of the address space.
      cyc(1, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'h44, 32'hFFFF_FFFC, 0);
      cyc(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0, 1);
      cyc(1, 0, 0, 0, 0, 1, 32'h0, 32'h4, 1);
      // Misaligned branch target.
      cyc(1, 0, 1, 32'h102, 0, 1, 32'h4, MIS_PC, 0);
      cyc(1, 0, 0, 0, 0, 1, MIS_PC, MIS_PC + 32'h4, 1);
      check("misalign_pulse", {31'b0, misalign}, {31'b0, MIS_EXP});
      cyc(0, 0, 0, 0, 0, 1, MIS_PC + 32'h4, MIS_PC + 32'h4, 0);
      check("misalign_clear", {31'b0, misalign}, 32'h0);

      // Random ack pattern on a sequential stream.
      pc_exp = MIS_PC + 32'h4;
      for (int i = 0; i < 24; i++) begin
         a = 1'($urandom_range(0, 1));
         cyc(a, 0, 0, 0, 0, 1, pc_exp, a ? pc_exp + 32'h4 : pc_exp, a);
         if (a) pc_exp = pc_exp + 32'h4;
      end
      cyc(0, 0, 0, 0, 0, 1, pc_exp, pc_exp, 0);

      // Reset in the middle of an outstanding request.
      mon_en = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_req", {31'b0, imem_if.imemReq}, 32'h0);
      check("midrst_next", next_address, 32'h0);
      check("midrst_state", {30'b0, dbg_state}, 32'h0);
      @(negedge clk);
      #1;
      check("midrst_fvalid", {31'b0, fetch_valid}, 32'h0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      #1;
      check("reboot_req", {31'b0, imem_if.imemReq}, 32'h0);
      cyc(1, 0, 0, 0, 0, 1, 32'h0, 32'h4, 1);
      cyc(0, 0, 0, 0, 0, 1, 32'h4, 32'h4, 0);
      cyc(0, 0, 0, 0, 0, 1, 32'h4, 32'h4, 0);

      check("queue_empty", exp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch controller that sequences the `program_counter` register and drives instruction-memory requests. Each cycle it chooses the PC's `nextAddress`: hold, sequential +4, branch target, trap vector, or reset vector. It also runs a req/ack handshake with instruction memory and squashes wrong-path fetches. It sits between the execute/branch-resolution logic and the PC register at the front of the datapath.

## Interface
- `RESET_VECTOR`, default `32'h0000_0000`, address loaded into the PC after reset release
- `TRAP_VECTOR`, default `32'h0000_0080`, redirect address for traps
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `currentAddress`  in  32  present value of the `program_counter` register
- `nextAddress`  out  32  value loaded into `program_counter` on the next edge
- `imemReq`  out  1  instruction-memory request
- `imemAddr`  out  32  request address; equals `currentAddress`
- `imemAck`  in  1  memory accepted/returned the request this cycle
- `stall`  in  1  downstream cannot accept a new fetch
- `branchTaken`  in  1  taken-branch redirect, single-cycle pulse
- `branchTarget`  in  32  branch target, valid with `branchTaken`
- `trap`  in  1  trap redirect, single-cycle pulse
- `fetchValid`  out  1  registered pulse: the fetch at `fetchAddress` completed on the correct path
- `fetchAddress`  out  32  address of the completed fetch
- `misalign`  out  1  registered pulse: misaligned branch target converted to a trap

## Operation
- **States:** BOOT, REQ, STALL.
- **Reset (`rst` low):**
  - State goes to BOOT asynchronously.
  - `imemReq` drops immediately.
  - The pending-redirect register (`pendValid`, `pendTarget`) clears.
  - `fetchValid`=0, `fetchAddress`=0, `misalign`=0.
  - `nextAddress`=`RESET_VECTOR`.
- **BOOT:**
  - `imemReq`=0, `nextAddress`=`RESET_VECTOR`.
  - Next state is REQ unconditionally (one cycle).
- **Redirect selection:** the redirect target `rt` is chosen in priority order:
  - `trap` → `TRAP_VECTOR`.
  - Otherwise `branchTaken` → `branchTarget`.
  - Otherwise `pendValid` → `pendTarget`.
- **REQ:**
  - `imemReq`=1. `imemAddr` is stable because `nextAddress`=`currentAddress` until ack.
  - Without `imemAck`:
    - `nextAddress`=`currentAddress`; stay in REQ.
    - An incoming `trap` writes the pending register with `TRAP_VECTOR` (overwrites a pending branch).
    - An incoming `branchTaken` writes the pending register only if no trap is pending.
  - With `imemAck`:
    - If any redirect is active: `nextAddress`=`rt`, `fetchValid` stays 0 (squash), pending register clears.
    - Otherwise: `nextAddress`=`currentAddress`+4, with `fetchValid`<=1 and `fetchAddress`<=`currentAddress`.
    - Next state is STALL if `stall`=1, else REQ.
- **STALL:**
  - `imemReq`=0.
  - `nextAddress`=`rt` if a redirect is active (pending register clears), else `currentAddress`.
  - Next state is REQ when `stall`=0.
- **Stall during an outstanding request:** `stall` is ignored until ack; a started request always completes.
- **Arithmetic:** +4 is modulo 2^32, so `32'hFFFF_FFFC` → `32'h0000_0000`.
- **Trap and branch in the same cycle:** the trap wins and the branch is discarded.
- `imemAck` while `imemReq`=0 is ignored.

## Timing
- `nextAddress` is combinational from state, pending register, and inputs. The PC updates one edge later.
- **Sequential fetch:** with ack every cycle, one fetch per cycle and `currentAddress` advances by 4 per cycle. `fetchValid` rises the edge after each ack.
- **Redirect latency:**
  - In STALL, or in REQ on an ack cycle: `currentAddress`=target after 1 edge.
  - In REQ without ack: `currentAddress`=target 1 edge after the ack arrives.
- **After reset release:** BOOT takes cycle 0, and the first `imemReq` is asserted in cycle 1 with `imemAddr`=`RESET_VECTOR`.

## Configuration
- **`PC_ALIGN_CHECK_EN` defined:**
  - A `branchTaken` with `branchTarget[1:0]`≠0 is treated as `trap`: it redirects to `TRAP_VECTOR` with the same trap priority.
  - `misalign` is asserted for one cycle, the edge after that branch is sampled.
- **`PC_ALIGN_CHECK_EN` undefined:**
  - `branchTarget[1:0]` is forced to 0 when used.
  - `misalign` is tied to 0.

## Test plan
- Reset release, ack held 1 → `imemAddr` sequence 0x0, 0x4, 0x8; `fetchValid` pulses with `fetchAddress` 0x0, 0x4.
- `imemAck` withheld 3 cycles at 0x8 → `imemReq`=1 and `imemAddr`=0x8 stable; `fetchValid`=0 throughout.
- Branch to 0x100 while waiting for ack at 0x8, ack 2 cycles later → 0x8 fetch squashed; next `imemAddr`=0x100.
- `trap` and `branchTaken`(0x200) in the same cycle → PC=0x80; 0x200 never fetched.
- `stall` held 4 cycles after the ack at 0x10 → `imemReq`=0, PC holds 0x14; fetch of 0x14 issued the cycle after `stall` drops.
- PC at 0xFFFF_FFFC with ack → next PC 0x0. With `PC_ALIGN_CHECK_EN`: branch to 0x102 → PC=0x80 and a one-cycle `misalign`. Also: `rst` low mid-request → `imemReq`=0 immediately.
